mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between instruction fetch (IF) and the load/store (data, D) path.
//  D requests are driven by the MemRead/MemWrite decode controls; IF requests are read-only.
//  Sequences one outstanding transaction at a time over a req/gnt/rvalid memory handshake.
//  Routes each response back to the requester that owns the transaction.
//  Priority: D over IF, plus a starvation guard that forces an IF grant.
//  Sits between the core's fetch/MEM stages and the unified memory.
// PARAMETERS
//  ADDR_WIDTH    32  address width, both requesters and memory
//  DATA_WIDTH    32  data width; byte enable width is DATA_WIDTH/8
//  STARVE_LIMIT  4   consecutive D grants with IF pending before IF is forced; must be >=1
// PORTS
//  clk_i        in   1     clock, rising edge
//  rst_ni       in   1     asynchronous active-low reset
//  if_req_i     in   1     IF read request; held with if_addr_i stable until if_gnt_o
//  if_addr_i    in   AW    IF address
//  if_gnt_o     out  1     IF request accepted by memory this cycle
//  if_rvalid_o  out  1     IF read data valid
//  if_rdata_o   out  DW    IF read data
//  d_req_i      in   1     data request (MemRead_o | MemWrite_o); held stable until d_gnt_o
//  d_we_i       in   1     1 = store, 0 = load
//  d_be_i       in   DW/8  byte enables (sb/sh/sw, lb/lh/lw)
//  d_addr_i     in   AW    data address
//  d_wdata_i    in   DW    store data
//  d_gnt_o      out  1     data request accepted by memory this cycle
//  d_rvalid_o   out  1     load data valid, or store acknowledge
//  d_rdata_o    out  DW    load data; don't-care on store ack
//  mem_req_o    out  1     memory request (registered)
//  mem_we_o     out  1     memory write enable (registered)
//  mem_be_o     out  DW/8  memory byte enables (registered)
//  mem_addr_o   out  AW    memory address (registered)
//  mem_wdata_o  out  DW    memory write data (registered)
//  mem_gnt_i    in   1     memory accepts the request this cycle
//  mem_rvalid_i in   1     memory response; exactly one per accepted request, reads and writes
//  mem_rdata_i  in   DW    memory read data
//  busy_o       out  1     a transaction is in flight (state != IDLE)
//  proto_err_o  out  1     sticky; set when mem_rvalid_i arrives while no response is expected
// BEHAVIOUR
//  Reset: state=IDLE, owner=IF, starve_cnt=0, proto_err_o=0; all mem_* outputs 0;
//   all gnt/rvalid outputs 0.
//  FSM IDLE -> REQ -> RESP.
//  IDLE: arbitrate when any request is present; register the winner's fields onto mem_*;
//   latch owner; go to REQ. mem_req_o rises the cycle after the request is seen.
//  REQ: mem_req_o=1; mem_* fields held stable. On mem_gnt_i: pulse the owner's gnt
//   combinationally in that cycle, drop mem_req_o, go to RESP.
//  RESP: wait for mem_rvalid_i, then pass mem_rdata_i and rvalid to the owner combinationally.
//   Same cycle: if any request is pending (not the one just served), arbitrate and go directly
//   to REQ (back-to-back, no idle bubble); otherwise go to IDLE.
//  Arbitration: D wins unless starve_cnt==STARVE_LIMIT and if_req_i=1, in which case IF wins.
//  starve_cnt: +1 on each D grant while if_req_i=1; cleared on an IF grant or whenever
//   if_req_i=0; saturates at STARVE_LIMIT.
//  A requester dropping its req before its gnt is a protocol violation; behaviour undefined.
//  mem_rvalid_i in IDLE or REQ: ignored (no rvalid forwarded); sets proto_err_o.
//  Reset mid-transaction: immediately IDLE; the in-flight response is discarded.
//  Minimum latency, idle memory with 0-wait gnt and 1-cycle rvalid:
//   req at N -> gnt at N+1 -> rvalid at N+2.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum {IDLE,REQ,RESP} arb_state_e; typedef enum {OWN_IF,OWN_D} owner_e.
//  Sub-module mem_arb_select: combinational winner pick plus starve_cnt register.
//  Top level: FSM, mem_* output registers, response routing.
// TESTING
//  1. IF-only: if_req with addr 0x100, mem gnt 0-wait, rvalid with 0xDEADBEEF
//     -> if_gnt at N+1, if_rvalid with 0xDEADBEEF at N+2; d_* outputs stay 0.
//  2. Simultaneous if_req and d_req (load 0x200) -> D served first, then IF back-to-back;
//     mem_req_o never drops between them.
//  3. Store sb: d_be=4'b0010, wdata 0x0000AB00 -> mem_we_o=1, mem_be_o=0010 held through a
//     3-cycle gnt wait; d_rvalid_o on ack.
//  4. Starvation: if_req held high, d_req held high -> exactly 4 D grants, then 1 IF grant,
//     then the counter restarts.
//  5. rst_ni low while in RESP -> all outputs 0 asynchronously; the later mem_rvalid_i is not
//     forwarded and proto_err_o=1.
//  6. Stray mem_rvalid_i in IDLE -> proto_err_o=1 and stays 1 until reset; no rvalid output.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state/owner types and counter sizing for the IF/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} arb_state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner pick between IF and D (D first) with a saturating starvation counter.
// Combinational pick; counter updates on the grant pulses, no backpressure of its own.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   if_req_i,
  input  logic   d_req_i,
  input  logic   if_gnt_i,
  input  logic   d_gnt_i,
  output owner_e winner_o
);
  localparam int unsigned CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q;
  logic          force_if;

  assign force_if = if_req_i && (starve_cnt_q == LIMIT);
  assign winner_o = (d_req_i && !force_if) ? OWN_D : OWN_IF;

  // Counts D grants only while IF is actually waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else if (!if_req_i || if_gnt_i) begin
      starve_cnt_q <= '0;
    end else if (d_gnt_i && (starve_cnt_q != LIMIT)) begin
      starve_cnt_q <= starve_cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF and D, one transaction in flight at a time.
// Request reaches mem_req_o one cycle after it is seen; requesters hold req until their gnt.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o,
  output logic                    proto_err_o
);
  arb_state_e state_q, state_d;
  owner_e     owner_q, winner;
  logic       any_req, launch;

  assign any_req = if_req_i | d_req_i;
  assign busy_o  = (state_q != IDLE);

  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .if_req_i (if_req_i),
    .d_req_i  (d_req_i),
    .if_gnt_i (if_gnt_o),
    .d_gnt_i  (d_gnt_o),
    .winner_o (winner)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A new request launched in RESP goes straight back to REQ without an idle bubble.
  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    if_rdata_o  = '0;
    d_rdata_o   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          launch  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          if_gnt_o = (owner_q == OWN_IF);
          d_gnt_o  = (owner_q == OWN_D);
          state_d  = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          if_rvalid_o = (owner_q == OWN_IF);
          d_rvalid_o  = (owner_q == OWN_D);
          if_rdata_o  = (owner_q == OWN_IF) ? mem_rdata_i : '0;
          d_rdata_o   = (owner_q == OWN_D)  ? mem_rdata_i : '0;
          launch      = any_req;
          state_d     = any_req ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      owner_q     <= OWN_IF;
    end else if (launch) begin
      mem_req_o <= 1'b1;
      owner_q   <= winner;
      if (winner == OWN_D) begin
        mem_we_o    <= d_we_i;
        mem_be_o    <= d_be_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
      end else begin
        mem_we_o    <= 1'b0;
        mem_be_o    <= '1;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
      end
    end else if ((state_q == REQ) && mem_gnt_i) begin
      mem_req_o <= 1'b0;
    end
  end

  // Any response outside RESP has no owner; it is dropped and flagged until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              proto_err_o <= 1'b0;
    else if (mem_rvalid_i && state_q != RESP) proto_err_o <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences and random traffic
// against a transaction-level reference with a byte-enabled memory model.
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i, d_req_i, d_we_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [3:0]  d_be_i;
  logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_req_o, mem_we_o, busy_o, proto_err_o;
  logic [3:0]  mem_be_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requesters
  bit          if_pend, d_pend, d_we_v, rnd_mode, cont_mode;
  logic [31:0] if_addr_v, d_addr_v, d_wdata_v;
  logic [3:0]  d_be_v;

  // Reference: the transaction the arbiter should be working on, plus sticky error
  bit          tx_live, tx_gnt, tx_d, tx_we, m_err;
  logic [31:0] tx_addr, tx_wdata;
  logic [3:0]  tx_be;
  int          starve;

  // Memory model
  logic [31:0] mem_store [logic [29:0]];
  int          gnt_wait, rv_delay, wcnt, rv_cnt;
  bit          rv_pend, stray_rv;
  logic [31:0] rv_dat;

  // Per-vector observations of DUT outputs
  int          cyc, first_gnt, second_gnt, first_rv;
  bit          first_d, cap_seen, cap_we;
  logic [31:0] first_rdata, cap_addr;
  logic [3:0]  cap_be;
  bit          grant_log[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_store.exists(a[31:2])) return mem_store[a[31:2]];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_store[a[31:2]] = w;
  endtask

  task automatic mem_drive();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom();
    if (rv_pend) begin
      rv_cnt--;
      if (rv_cnt <= 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rv_dat;
        rv_pend      = 1'b0;
      end
    end else if (stray_rv) begin
      mem_rvalid_i = 1'b1;
      stray_rv     = 1'b0;
    end
    if (mem_req_o && !rv_pend && !mem_rvalid_i) begin
      if (wcnt >= gnt_wait) begin
        mem_gnt_i = 1'b1;
        wcnt      = 0;
        rv_dat    = mem_rd(mem_addr_o);
        if (mem_we_o) mem_wr(mem_addr_o, mem_be_o, mem_wdata_o);
        rv_pend   = 1'b1;
        rv_cnt    = rnd_mode ? int'($urandom_range(1, 3)) : rv_delay;
        if (rnd_mode) gnt_wait = $urandom_range(0, 3);
      end else begin
        wcnt++;
      end
    end
  endtask

  task automatic observe();
    if (if_gnt_o || d_gnt_o) begin
      grant_log.push_back(d_gnt_o);
      if (first_gnt < 0) begin
        first_gnt = cyc;
        first_d   = d_gnt_o;
      end else if (second_gnt < 0) begin
        second_gnt = cyc;
      end
    end
    if ((if_rvalid_o || d_rvalid_o) && first_rv < 0) begin
      first_rv    = cyc;
      first_rdata = d_rvalid_o ? d_rdata_o : if_rdata_o;
    end
    if (mem_req_o && !cap_seen) begin
      cap_seen = 1'b1;
      cap_addr = mem_addr_o;
      cap_we   = mem_we_o;
      cap_be   = mem_be_o;
    end
  endtask

  task automatic model_step();
    bit exp_mreq, exp_ig, exp_dg, exp_ir, exp_dr;
    exp_mreq = tx_live && !tx_gnt;
    exp_ig   = exp_mreq && mem_gnt_i && !tx_d;
    exp_dg   = exp_mreq && mem_gnt_i && tx_d;
    exp_ir   = tx_live && tx_gnt && mem_rvalid_i && !tx_d;
    exp_dr   = tx_live && tx_gnt && mem_rvalid_i && tx_d;
    chk("busy", busy_o, tx_live);
    chk("mem_req", mem_req_o, exp_mreq);
    chk("if_gnt", if_gnt_o, exp_ig);
    chk("d_gnt", d_gnt_o, exp_dg);
    chk("if_rvalid", if_rvalid_o, exp_ir);
    chk("d_rvalid", d_rvalid_o, exp_dr);
    chk("proto_err", proto_err_o, m_err);
    if (exp_mreq) begin
      chk("mem_addr", mem_addr_o, tx_addr);
      chk("mem_we", mem_we_o, tx_we);
      if (tx_d) chk("mem_be", mem_be_o, tx_be);
      if (tx_we) chk("mem_wdata", mem_wdata_o, tx_wdata);
    end
    if (exp_ir) chk("if_rdata", if_rdata_o, mem_rdata_i);
    if (exp_dr && !tx_we) chk("d_rdata", d_rdata_o, mem_rdata_i);
    if (!rst_ni) return;
    if (mem_rvalid_i && !(tx_live && tx_gnt)) m_err = 1'b1;
    if (!if_req_i || exp_ig) starve = 0;
    else if (exp_dg && starve < LIM) starve++;
    if (exp_ig) begin
      if_pend = cont_mode;
      if_addr_v += 4;
    end
    if (exp_dg) begin
      d_pend = cont_mode;
      d_addr_v += 4;
    end
    if (exp_mreq && mem_gnt_i) tx_gnt = 1'b1;
    else if (tx_live && tx_gnt && mem_rvalid_i) tx_live = 1'b0;
    // Any request seen while nothing is in flight starts the next transaction.
    if (!tx_live && (if_req_i || d_req_i)) begin
      tx_d     = d_req_i && !(if_req_i && starve == LIM);
      tx_live  = 1'b1;
      tx_gnt   = 1'b0;
      tx_we    = tx_d ? d_we_i : 1'b0;
      tx_addr  = tx_d ? d_addr_i : if_addr_i;
      tx_be    = d_be_i;
      tx_wdata = d_wdata_i;
    end
    if (rnd_mode) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend   = 1'b1;
        if_addr_v = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend    = 1'b1;
        d_we_v    = $urandom_range(0, 1);
        d_be_v    = 4'($urandom_range(1, 15));
        d_addr_v  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        d_wdata_v = $urandom();
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    mem_drive();
    if_req_i  = if_pend;
    if_addr_i = if_addr_v;
    d_req_i   = d_pend;
    d_we_i    = d_we_v;
    d_be_i    = d_be_v;
    d_addr_i  = d_addr_v;
    d_wdata_i = d_wdata_v;
    #1;
    observe();
    model_step();
    cyc++;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((tx_live || if_pend || d_pend || rv_pend) && k < 100) begin
      cycle();
      k++;
    end
    chk({name, "_drained"}, k < 100, 1);
  endtask

  task automatic assert_reset();
    rst_ni  = 1'b0;
    tx_live = 1'b0; tx_gnt = 1'b0; m_err = 1'b0; starve = 0;
    if_pend = 1'b0; d_pend = 1'b0; wcnt = 0;
  endtask

  typedef struct {
    bit if_req; logic [31:0] if_addr;
    bit d_req; bit d_we; logic [3:0] d_be; logic [31:0] d_addr; logic [31:0] d_wdata;
    int gnt_wait; int rv_delay;
    bit exp_d_first; bit exp_we; logic [3:0] exp_be; logic [31:0] exp_addr;
    int exp_gnt1; int exp_gnt2; int exp_rv1; logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl[6];

  initial begin
    // if_req if_addr | d_req we be addr wdata | gnt_wait rv_delay | exp: d_first we be addr gnt1 gnt2 rv1 rdata
    tbl[0] = '{1, 32'h100, 0, 0, 4'hF, 32'h0,   32'h0,         0, 1, 0, 0, 4'hF, 32'h100, 1, -1, 2, 32'hDEADBEEF};
    tbl[1] = '{1, 32'h104, 1, 0, 4'hF, 32'h200, 32'h0,         0, 1, 1, 0, 4'hF, 32'h200, 1,  3, 2, 32'h5A5A585A};
    tbl[2] = '{0, 32'h0,   1, 1, 4'h2, 32'h300, 32'h0000AB00,  3, 1, 1, 1, 4'h2, 32'h300, 4, -1, 5, 32'h0};
    tbl[3] = '{0, 32'h0,   1, 0, 4'hF, 32'h300, 32'h0,         2, 3, 1, 0, 4'hF, 32'h300, 3, -1, 6, 32'h5A5AAB5A};
    tbl[4] = '{1, 32'h108, 1, 1, 4'hC, 32'h300, 32'h12340000,  0, 2, 1, 1, 4'hC, 32'h300, 1,  4, 3, 32'h0};
    tbl[5] = '{0, 32'h0,   1, 0, 4'hF, 32'h300, 32'h0,         1, 1, 1, 0, 4'hF, 32'h300, 2, -1, 3, 32'h1234AB5A};

    mem_store[30'h40] = 32'hDEADBEEF;
    {if_req_i, d_req_i, d_we_i, mem_gnt_i, mem_rvalid_i} = '0;
    {if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i, d_be_i} = '0;
    {if_addr_v, d_addr_v, d_wdata_v, d_be_v, d_we_v} = '0;
    {rnd_mode, cont_mode, rv_pend, stray_rv} = '0;
    gnt_wait = 0; rv_delay = 1; cyc = 0;
    assert_reset();
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_fields", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
    chk("rst_gnt_rvalid", {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o}, 0);
    chk("rst_proto_err", proto_err_o, 0);
    rst_ni = 1'b1;
    repeat (2) cycle();

    for (int i = 0; i < 6; i++) begin
      int k;
      gnt_wait = tbl[i].gnt_wait; rv_delay = tbl[i].rv_delay;
      if_pend = tbl[i].if_req; if_addr_v = tbl[i].if_addr;
      d_pend = tbl[i].d_req; d_we_v = tbl[i].d_we; d_be_v = tbl[i].d_be;
      d_addr_v = tbl[i].d_addr; d_wdata_v = tbl[i].d_wdata;
      cyc = 0; first_gnt = -1; second_gnt = -1; first_rv = -1; cap_seen = 1'b0;
      k = 0;
      while ((tx_live || if_pend || d_pend || rv_pend) && k < 60) begin
        cycle();
        k++;
      end
      chk($sformatf("v%0d_done", i), k < 60, 1);
      chk($sformatf("v%0d_first_owner", i), first_d, tbl[i].exp_d_first);
      chk($sformatf("v%0d_mem_addr", i), cap_addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_mem_we", i), cap_we, tbl[i].exp_we);
      if (tbl[i].exp_d_first) chk($sformatf("v%0d_mem_be", i), cap_be, tbl[i].exp_be);
      chk($sformatf("v%0d_gnt_cycle", i), first_gnt, tbl[i].exp_gnt1);
      chk($sformatf("v%0d_second_gnt_cycle", i), second_gnt, tbl[i].exp_gnt2);
      chk($sformatf("v%0d_rvalid_cycle", i), first_rv, tbl[i].exp_rv1);
      if (!tbl[i].exp_we) chk($sformatf("v%0d_rdata", i), first_rdata, tbl[i].exp_rdata);
      cycle();
    end

    // Starvation guard: both requesters hammer continuously.
    gnt_wait = 0; rv_delay = 1; cont_mode = 1'b1; grant_log.delete();
    if_pend = 1'b1; if_addr_v = 32'h400; d_pend = 1'b1; d_we_v = 1'b0; d_be_v = 4'hF; d_addr_v = 32'h500;
    begin
      int k = 0;
      while (grant_log.size() < 10 && k < 200) begin
        cycle();
        k++;
      end
    end
    chk("starve_grants_seen", grant_log.size() >= 10, 1);
    for (int i = 0; i < 10; i++)
      if (i < grant_log.size()) chk($sformatf("starve_grant%0d_is_d", i), grant_log[i], (i % 5 == 4) ? 0 : 1);
    cont_mode = 1'b0;
    drain("starve");
    cycle();

    // Reset while waiting for a response: outputs clear at once, late response is stray.
    if_pend = 1'b1; if_addr_v = 32'h140; gnt_wait = 0; rv_delay = 4;
    repeat (3) cycle();
    chk("pre_rst_busy", busy_o, 1);
    #2;
    assert_reset();
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_outputs", {mem_req_o, if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, proto_err_o}, 0);
    chk("arst_mem_fields", {mem_we_o, mem_be_o, mem_addr_o}, 0);
    cycle();
    rst_ni = 1'b1;
    repeat (3) cycle();
    chk("late_rvalid_err", proto_err_o, 1);
    chk("late_rvalid_rv_pend", rv_pend, 0);

    // Stray response in IDLE sets the sticky flag, which survives further traffic.
    assert_reset();
    cycle();
    rst_ni = 1'b1;
    repeat (2) cycle();
    stray_rv = 1'b1;
    cycle();
    cycle();
    chk("stray_err", proto_err_o, 1);
    if_pend = 1'b1; if_addr_v = 32'h180; rv_delay = 1;
    drain("stray");
    repeat (2) cycle();
    chk("stray_err_sticky", proto_err_o, 1);
    assert_reset();
    #1;
    chk("stray_err_cleared", proto_err_o, 0);
    cycle();
    rst_ni = 1'b1;

    // Random mixed traffic with random memory latencies.
    rnd_mode = 1'b1;
    repeat (3000) cycle();
    rnd_mode = 1'b0;
    drain("random");
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
